// File: rtl/mfp_multi_digit_display_pwm_pkg.sv
// -----------------------------------------------------------------------------
// mfp_multi_digit_display_pwm_pkg
//
// Shared definitions for the multi-digit seven-segment scanner:
//   - active-high hex-to-segment encodings, bit order {g,f,e,d,c,b,a}
//   - clog2_int: constant-foldable ceiling log2 used to size the counters
// -----------------------------------------------------------------------------
package mfp_multi_digit_display_pwm_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
    localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
    localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
    localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
    localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
    localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
    localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b1111100;
    localparam logic [6:0] SEG_HEX_C = 7'b0111001;
    localparam logic [6:0] SEG_HEX_D = 7'b1011110;
    localparam logic [6:0] SEG_HEX_E = 7'b1111001;
    localparam logic [6:0] SEG_HEX_F = 7'b1110001;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2_int(input int unsigned value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mfp_hex_to_seven_segments.sv
// -----------------------------------------------------------------------------
// mfp_hex_to_seven_segments
//
// Purely combinational hex nibble to seven-segment decoder, active-high.
//   hex : 4-bit value 0..F
//   seg : segments, bit 0 = a ... bit 6 = g, 1 = segment lit
// -----------------------------------------------------------------------------
module mfp_hex_to_seven_segments
    import mfp_multi_digit_display_pwm_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_HEX_0;
        case (hex)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_HEX_0;
        endcase
    end

endmodule

// File: rtl/mfp_multi_digit_display_pwm.sv
// -----------------------------------------------------------------------------
// mfp_multi_digit_display_pwm
//
// Time-multiplexed N_DIGITS hex display driver with PWM brightness, per-digit
// dots, digit-enable mask, optional leading-zero blanking and a one-cycle dark
// gap at the start of every digit slot to avoid ghosting.
//
// Inputs are captured once per frame (last cycle of the last slot), so a digit
// never changes halfway through a scan.
//
// Ports:
//   clock, resetn      : clock, asynchronous active-low reset
//   number             : 4*N_DIGITS hex nibbles, nibble i drives digit i
//   dots               : per-digit decimal point request
//   digit_en           : per-digit enable, 0 keeps the digit dark
//   blank_lz           : enable leading-zero blanking
//   brightness         : PWM level, 0 dimmest, all-ones full on
//   seven_segments     : segments a..g (bit 0 = a), polarity per SEG_ACTIVE_LOW
//   dot                : decimal point, polarity per SEG_ACTIVE_LOW
//   anodes             : one-hot digit select, polarity per ANODE_ACTIVE_LOW
//   frame_start        : one-cycle pulse on the first output cycle of a frame
//                        that uses a freshly captured snapshot
//
// All outputs are registered and reflect the counter state of the previous
// cycle.
// -----------------------------------------------------------------------------
module mfp_multi_digit_display_pwm
    import mfp_multi_digit_display_pwm_pkg::*;
#(
    parameter int N_DIGITS         = 8,
    parameter int REFRESH_DIV      = 64,
    parameter int BRIGHT_W         = 3,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [4*N_DIGITS-1:0]   number,
    input  logic [N_DIGITS-1:0]     dots,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seven_segments,
    output logic                    dot,
    output logic [N_DIGITS-1:0]     anodes,
    output logic                    frame_start
);

    localparam int PHASE_W = clog2_int(REFRESH_DIV);
    localparam int DIGIT_W = (N_DIGITS > 1) ? clog2_int(N_DIGITS) : 1;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(REFRESH_DIV - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(N_DIGITS - 1);

    // Inactive levels of the pins.
    localparam logic AN_OFF  = (ANODE_ACTIVE_LOW != 0);
    localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);

    // -------------------------------------------------------------------------
    // Scan counters
    // -------------------------------------------------------------------------
    logic [PHASE_W-1:0] phase;
    logic [DIGIT_W-1:0] digit;
    logic               frame_end;

    assign frame_end = (phase == PHASE_LAST) && (digit == DIGIT_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            phase <= '0;
            digit <= '0;
        end else begin
            // REFRESH_DIV is a power of two, so phase wraps on its own.
            phase <= phase + PHASE_W'(1);
            if (phase == PHASE_LAST) begin
                digit <= (digit == DIGIT_LAST) ? '0 : digit + DIGIT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame snapshot
    // -------------------------------------------------------------------------
    logic [4*N_DIGITS-1:0] snap_number;
    logic [N_DIGITS-1:0]   snap_dots;
    logic [N_DIGITS-1:0]   snap_digit_en;
    logic                  snap_blank_lz;
    logic [BRIGHT_W-1:0]   snap_brightness;
    // High for the one cycle in which the counters sit at (0,0) with a newly
    // captured snapshot; registered once more it becomes frame_start.
    logic                  snap_fresh;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            snap_number     <= '0;
            snap_dots       <= '0;
            snap_digit_en   <= '0;
            snap_blank_lz   <= 1'b0;
            snap_brightness <= '0;
            snap_fresh      <= 1'b0;
        end else begin
            snap_fresh <= frame_end;
            if (frame_end) begin
                snap_number     <= number;
                snap_dots       <= dots;
                snap_digit_en   <= digit_en;
                snap_blank_lz   <= blank_lz;
                snap_brightness <= brightness;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero detection: lz_blank[i] is set when every nibble from the
    // top down to i is zero. Digit 0 always shows, so a zero value reads "0".
    // -------------------------------------------------------------------------
    logic [N_DIGITS-1:0] lz_blank;
    logic                upper_zero;

    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero  = upper_zero && (snap_number[4*i +: 4] == 4'h0);
            lz_blank[i] = snap_blank_lz && (i != 0) && upper_zero;
        end
    end

    // -------------------------------------------------------------------------
    // Current-digit selection (loop compare keeps index widths exact for any
    // N_DIGITS).
    // -------------------------------------------------------------------------
    logic [3:0]          cur_nibble;
    logic                cur_en;
    logic                cur_dot;
    logic                cur_blank;
    logic [N_DIGITS-1:0] anode_onehot;

    always_comb begin
        cur_nibble   = 4'h0;
        cur_en       = 1'b0;
        cur_dot      = 1'b0;
        cur_blank    = 1'b0;
        anode_onehot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit == DIGIT_W'(i)) begin
                cur_nibble      = snap_number[4*i +: 4];
                cur_en          = snap_digit_en[i];
                cur_dot         = snap_dots[i];
                cur_blank       = lz_blank[i];
                anode_onehot[i] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // PWM: the top BRIGHT_W phase bits split the slot into 2**BRIGHT_W equal
    // windows; windows up to the brightness level are lit, minus phase 0 which
    // is always dark.
    // -------------------------------------------------------------------------
    logic [BRIGHT_W-1:0] pwm_slot;
    logic                lit;

    assign pwm_slot = phase[PHASE_W-1 -: BRIGHT_W];
    assign lit      = (phase != '0) && (pwm_slot <= snap_brightness) && cur_en;

    logic [6:0] seg_active_high;

    mfp_hex_to_seven_segments u_hex_to_seven_segments (
        .hex (cur_nibble),
        .seg (seg_active_high)
    );

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            anodes         <= {N_DIGITS{AN_OFF}};
            seven_segments <= {7{SEG_OFF}};
            dot            <= SEG_OFF;
            frame_start    <= 1'b0;
        end else begin
            frame_start <= snap_fresh;
            if (lit) begin
                anodes         <= anode_onehot ^ {N_DIGITS{AN_OFF}};
                // Blanked digits keep their anode so the dot can still show.
                seven_segments <= cur_blank ? {7{SEG_OFF}}
                                            : (seg_active_high ^ {7{SEG_OFF}});
                dot            <= cur_dot ? ~SEG_OFF : SEG_OFF;
            end else begin
                anodes         <= {N_DIGITS{AN_OFF}};
                seven_segments <= {7{SEG_OFF}};
                dot            <= SEG_OFF;
            end
        end
    end

endmodule
